// File: rtl/sram_weight_loader.sv
// Byte-stream to 72-bit SRAM word packer driving the weight SRAM write port.
// Optional LOADER_CHECKSUM_EN adds a modulo-2^16 running sum of accepted bytes.
module sram_weight_loader #(
   parameter int DATA_W         = 8,
   parameter int BYTES_PER_WORD = 9,
   parameter int ADDR_W         = 10,
   parameter int DEPTH          = 576
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_W-1:0]                base_addr,
   input  logic [ADDR_W-1:0]                word_cnt,
   input  logic                             byte_valid,
   input  logic [DATA_W-1:0]                byte_data,
   output logic                             byte_ready,
   output logic                             write_en,
   output logic [DATA_W*BYTES_PER_WORD-1:0] data_w,
   output logic [ADDR_W-1:0]                addr_w,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic [15:0]                      checksum
);

   localparam int WORD_W = DATA_W * BYTES_PER_WORD;
   localparam int BUF_W  = WORD_W - DATA_W;
   localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      LAST_BYTE = 4'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FIN} state_t;

   state_t            state, state_next;
   logic [3:0]        byte_cnt;
   logic [BUF_W-1:0]  pack_buf;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] rem;
   logic [ADDR_W:0]   span;
   logic              range_bad;
   logic              start_ok;
   logic              accept;
   logic              last_byte;

   assign accept    = byte_valid && byte_ready;
   assign last_byte = (byte_cnt == LAST_BYTE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_next = state;
      span       = {1'b0, base_addr} + {1'b0, word_cnt};
      range_bad  = (span > DEPTH_V);
      start_ok   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !range_bad) begin
               start_ok   = 1'b1;
               state_next = (word_cnt == '0) ? FIN : COLLECT;
            end
         end
         COLLECT: if (accept && last_byte) state_next = WRITE;
         WRITE:   state_next = (rem != '0) ? COLLECT : FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   // NOTE: sequential state uses non-blocking assignments only, so evaluation order never matters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_ready <= 1'b0;
         write_en   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         data_w     <= '0;
         addr_w     <= '0;
         pack_buf   <= '0;
         next_addr  <= '0;
         rem        <= '0;
         byte_cnt   <= '0;
      end else begin
         byte_ready <= (state_next == COLLECT);
         write_en   <= (state_next == WRITE);
         busy       <= (state_next != IDLE);
         done       <= (state == FIN);

         if (start_ok)
            err <= 1'b0;
         else if (state == IDLE && start && range_bad)
            err <= 1'b1;

         if (start_ok) begin
            next_addr <= base_addr;
            rem       <= word_cnt;
            byte_cnt  <= '0;
         end else if (accept) begin
            if (last_byte) begin
               data_w    <= {byte_data, pack_buf};
               addr_w    <= next_addr;
               next_addr <= next_addr + 1'b1;
               rem       <= rem - 1'b1;
               byte_cnt  <= '0;
            end else begin
               pack_buf[int'(byte_cnt)*DATA_W +: DATA_W] <= byte_data;
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           checksum <= '0;
      else if (start_ok) checksum <= '0;
      else if (accept)   checksum <= checksum + 16'(byte_data);
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_sram_weight_loader.sv
// Self-checking bench for sram_weight_loader: table of load cases plus hand-written
// latency, mid-load restart and mid-load reset sequences; writes checked by a scoreboard.
module tb_sram_weight_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [9:0]  word_cnt;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        write_en;
   logic [71:0] data_w;
   logic [9:0]  addr_w;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] checksum;

   sram_weight_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_cnt   (word_cnt),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .write_en   (write_en),
      .data_w     (data_w),
      .addr_w     (addr_w),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  addr;
      logic [71:0] data;
   } wr_t;

   typedef struct {
      logic [9:0] base;
      logic [9:0] cnt;
      bit         gaps;
      bit         exp_err;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   wr_t        exp_q[$];
   logic [7:0] stim[$];
   vec_t       vecs[10];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: each write pops the next expected {addr, data}.
   always @(negedge clk) begin
      if (write_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 80'(addr_w), 80'h3ff);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 80'(addr_w), 80'(e.addr));
            check("wr_data", 80'(data_w), 80'(e.data));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Offers stim[0..n-1]; gaps drop byte_valid randomly. poke_at pulses a start mid-load.
   task automatic feed(input int n, input bit gaps, input int poke_at);
      int idx = 0;
      int cyc = 0;
      bit poked = 1'b0;
      bit v;
      if (n == 0) return;
      while (idx < n && cyc < n * 4 + 100) begin
         @(negedge clk);
         if (poke_at >= 0 && idx == poke_at && !poked) begin
            start = 1'b1; base_addr = 10'd10; word_cnt = 10'd2; poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         byte_valid = v;
         byte_data  = stim[idx];
         if (v && byte_ready) idx++;
         cyc++;
      end
      check("feed_progress", 80'(idx), 80'(n));
      @(negedge clk);
      byte_valid = 1'b0;
      start      = 1'b0;
   endtask

   // Builds random words starting at base, pushes expectations, returns the byte sum.
   task automatic build_stim(input logic [9:0] base, input int words, input int push_words,
                             output logic [15:0] sum);
      logic [71:0] w;
      logic [7:0]  b;
      sum = '0;
      stim.delete();
      for (int i = 0; i < words; i++) begin
         for (int k = 0; k < 9; k++) begin
            b = 8'($urandom);
            stim.push_back(b);
            w[8*k +: 8] = b;
            sum = sum + 16'(b);
         end
         if (i < push_words) exp_q.push_back('{addr: base + 10'(i), data: w});
      end
   endtask

   task automatic run_load(input logic [9:0] base, input logic [9:0] cnt, input bit gaps,
                           input bit exp_err, input int poke_at);
      logic [15:0] sum;
      logic [15:0] exp_cs;
      bit got_done = 1'b0;
      @(negedge clk);
      start = 1'b1; base_addr = base; word_cnt = cnt;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 80'(busy), 80'(!exp_err));
      check("err_after_start", 80'(err), 80'(exp_err));
      check("ready_after_start", 80'(byte_ready), 80'(!exp_err && cnt != 0));
      if (exp_err) begin
         repeat (12) @(negedge clk);
         check("busy_stays_low", 80'(busy), 80'(0));
         check("err_sticky", 80'(err), 80'(1));
         return;
      end
      build_stim(base, int'(cnt), int'(cnt), sum);
      feed(stim.size(), gaps, poke_at);
      for (int c = 0; c < 40; c++) begin
         if (done) begin got_done = 1'b1; break; end
         @(negedge clk);
      end
`ifdef LOADER_CHECKSUM_EN
      exp_cs = sum;
`else
      exp_cs = '0;
`endif
      check("done_seen", 80'(got_done), 80'(1));
      check("busy_at_done", 80'(busy), 80'(0));
      check("err_at_done", 80'(err), 80'(0));
      check("checksum", 80'(checksum), 80'(exp_cs));
      check("sb_drained", 80'(exp_q.size()), 80'(0));
      @(negedge clk);
      check("done_one_cycle", 80'(done), 80'(0));
   endtask

   initial begin
      logic [15:0] sum;
      logic [15:0] cs_2d;

      vecs[0] = '{base: 10'd0,   cnt: 10'd1,    gaps: 1'b0, exp_err: 1'b0};
      vecs[1] = '{base: 10'd570, cnt: 10'd6,    gaps: 1'b1, exp_err: 1'b0};
      vecs[2] = '{base: 10'd570, cnt: 10'd7,    gaps: 1'b0, exp_err: 1'b1};
      vecs[3] = '{base: 10'd100, cnt: 10'd3,    gaps: 1'b1, exp_err: 1'b0};
      vecs[4] = '{base: 10'd0,   cnt: 10'd0,    gaps: 1'b0, exp_err: 1'b0};
      vecs[5] = '{base: 10'd575, cnt: 10'd1,    gaps: 1'b1, exp_err: 1'b0};
      vecs[6] = '{base: 10'd1,   cnt: 10'd576,  gaps: 1'b0, exp_err: 1'b1};
      vecs[7] = '{base: 10'd0,   cnt: 10'd576,  gaps: 1'b0, exp_err: 1'b0};
      vecs[8] = '{base: 10'd0,   cnt: 10'd1023, gaps: 1'b0, exp_err: 1'b1};
      vecs[9] = '{base: 10'd566, cnt: 10'd10,   gaps: 1'b1, exp_err: 1'b0};

      rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
      byte_valid = 1'b0; byte_data = '0;
      repeat (3) @(negedge clk);
      check("rst_byte_ready", 80'(byte_ready), 80'(0));
      check("rst_write_en", 80'(write_en), 80'(0));
      check("rst_data_w", 80'(data_w), 80'(0));
      check("rst_addr_w", 80'(addr_w), 80'(0));
      check("rst_busy", 80'(busy), 80'(0));
      check("rst_done", 80'(done), 80'(0));
      check("rst_err", 80'(err), 80'(0));
      check("rst_checksum", 80'(checksum), 80'(0));
      rst = 1'b0;

      // Exact timing of a one-word load with bytes 0x01..0x09.
`ifdef LOADER_CHECKSUM_EN
      cs_2d = 16'h002d;
`else
      cs_2d = 16'h0000;
`endif
      exp_q.push_back('{addr: 10'd0, data: 72'h090807060504030201});
      @(negedge clk);
      start = 1'b1; base_addr = 10'd0; word_cnt = 10'd1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 0) begin
            check("lat_busy_rise", 80'(busy), 80'(1));
            check("lat_ready_rise", 80'(byte_ready), 80'(1));
         end
         byte_valid = 1'b1;
         byte_data  = 8'(k + 1);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      check("lat_write_en", 80'(write_en), 80'(1));
      check("lat_ready_low_in_write", 80'(byte_ready), 80'(0));
      @(negedge clk);
      check("lat_single_write", 80'(write_en), 80'(0));
      check("lat_done_not_early", 80'(done), 80'(0));
      check("lat_busy_fin", 80'(busy), 80'(1));
      @(negedge clk);
      check("lat_done", 80'(done), 80'(1));
      check("lat_busy_drop", 80'(busy), 80'(0));
      check("lat_checksum", 80'(checksum), 80'(cs_2d));
      check("lat_data_hold", 80'(data_w), 80'(72'h090807060504030201));
      @(negedge clk);
      check("lat_done_pulse", 80'(done), 80'(0));

      // Zero-word load: busy for one cycle, done two cycles after start.
      @(negedge clk);
      start = 1'b1; base_addr = 10'd5; word_cnt = 10'd0;
      @(negedge clk);
      start = 1'b0;
      check("zero_busy", 80'(busy), 80'(1));
      check("zero_done_early", 80'(done), 80'(0));
      @(negedge clk);
      check("zero_done", 80'(done), 80'(1));
      check("zero_busy_drop", 80'(busy), 80'(0));

      for (int i = 0; i < 10; i++)
         run_load(vecs[i].base, vecs[i].cnt, vecs[i].gaps, vecs[i].exp_err, -1);

      // start pulsed mid-load must not disturb the running address sequence.
      run_load(10'd200, 10'd3, 1'b1, 1'b0, 13);

      // Reset after 5 bytes of word 2 of 4; only word 1 is ever written.
      @(negedge clk);
      start = 1'b1; base_addr = 10'd300; word_cnt = 10'd4;
      @(negedge clk);
      start = 1'b0;
      build_stim(10'd300, 4, 1, sum);
      feed(14, 1'b0, -1);
      rst = 1'b1;
      #1;
      check("arst_busy", 80'(busy), 80'(0));
      check("arst_ready", 80'(byte_ready), 80'(0));
      check("arst_data_w", 80'(data_w), 80'(0));
      check("arst_addr_w", 80'(addr_w), 80'(0));
      check("arst_checksum", 80'(checksum), 80'(0));
      repeat (3) @(negedge clk);
      check("arst_write_en", 80'(write_en), 80'(0));
      rst = 1'b0;
      check("arst_sb_drained", 80'(exp_q.size()), 80'(0));
      run_load(10'd50, 10'd2, 1'b1, 1'b0, -1);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
